// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, fill FSM states, colour and command types.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;
  localparam int FB_PIXELS = FB_W * FB_H;

  // RGB444 colour, same encoding the display path scans out.
  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Fill command as captured from the request interface.
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    rgb444_t    color;
  } fill_cmd_t;

  // Start address of a row: y*320 built from shifts so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] fb_row_base(input logic [7:0] y);
    logic [FB_ADDR_W-1:0] w_y;
    w_y = {{(FB_ADDR_W-8){1'b0}}, y};
    return (w_y << 8) + (w_y << 6);
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a fill rectangle against the visible frame.
module rect_clip
  import fb_pkg::*;
#(
  parameter int CLIP_W = fb_pkg::FB_W,
  parameter int CLIP_H = fb_pkg::FB_H
) (
  input  logic [8:0] i_x,
  input  logic [7:0] i_y,
  input  logic [8:0] i_w,
  input  logic [7:0] i_h,
  output logic [9:0] o_x_end,
  output logic [8:0] o_y_end,
  output logic       o_empty
);

  logic [9:0] w_sum_x;
  logic [8:0] w_sum_y;

  // Right/bottom edges before clipping; widths chosen so the sums never wrap.
  assign w_sum_x = {1'b0, i_x} + {1'b0, i_w};
  assign w_sum_y = {1'b0, i_y} + {1'b0, i_h};

  // Clamp exclusive end coordinates to the frame and flag rectangles with no visible pixel.
  always_comb begin
    o_x_end = w_sum_x;
    o_y_end = w_sum_y;
    o_empty = 1'b0;
    if (w_sum_x > 10'(CLIP_W)) begin
      o_x_end = 10'(CLIP_W);
    end else begin
      o_x_end = w_sum_x;
    end
    if (w_sum_y > 9'(CLIP_H)) begin
      o_y_end = 9'(CLIP_H);
    end else begin
      o_y_end = w_sum_y;
    end
    if ((i_w == 9'd0) || (i_h == 8'd0) ||
        ({1'b0, i_x} >= 10'(CLIP_W)) || ({1'b0, i_y} >= 9'(CLIP_H))) begin
      o_empty = 1'b1;
    end else begin
      o_empty = 1'b0;
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle-fill engine: accepts one command, clips it, streams raster-order pixel writes.
module rect_fill_engine
  import fb_pkg::*;
#(
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int FB_H   = fb_pkg::FB_H,
  parameter int ADDR_W = fb_pkg::FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [11:0]       cmd_color,
  output logic              busy,
  output logic              done,
  output logic              fb_write,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wdata,
  input  logic              fb_grant
);

  fill_state_t       r_state;
  fill_cmd_t         r_cmd;
  logic [9:0]        r_x_end;
  logic [8:0]        r_y_end;
  logic [9:0]        r_cx;
  logic [8:0]        r_cy;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_done;
  logic              r_fb_write;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [31:0]       r_fb_wdata;

  logic [9:0]        w_x_end;
  logic [8:0]        w_y_end;
  logic              w_empty;
  logic [ADDR_W-1:0] w_first_row_base;
  logic [ADDR_W-1:0] w_next_row_base;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_consume;

  rect_clip #(
    .CLIP_W (FB_W),
    .CLIP_H (FB_H)
  ) u_clip (
    .i_x     (r_cmd.x),
    .i_y     (r_cmd.y),
    .i_w     (r_cmd.w),
    .i_h     (r_cmd.h),
    .o_x_end (w_x_end),
    .o_y_end (w_y_end),
    .o_empty (w_empty)
  );

  // Address helpers and end-of-row / end-of-rectangle detection for the current pixel.
  assign w_first_row_base = ADDR_W'(fb_row_base(r_cmd.y));
  assign w_next_row_base  = r_row_base + ADDR_W'(FB_W);
  assign w_last_col       = ((r_cx + 10'd1) >= r_x_end);
  assign w_last_row       = ((r_cy + 9'd1) >= r_y_end);
  assign w_consume        = r_fb_write & fb_grant;

  // Main FSM: command capture, setup, granted pixel stepping and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_x_end    <= 10'd0;
      r_y_end    <= 9'd0;
      r_cx       <= 10'd0;
      r_cy       <= 9'd0;
      r_row_base <= '0;
      r_done     <= 1'b0;
      r_fb_write <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done     <= 1'b0;
          r_fb_write <= 1'b0;
          if (cmd_valid) begin
            r_cmd   <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_x_end    <= w_x_end;
          r_y_end    <= w_y_end;
          r_row_base <= w_first_row_base;
          r_cx       <= {1'b0, r_cmd.x};
          r_cy       <= {1'b0, r_cmd.y};
          r_fb_addr  <= w_first_row_base + ADDR_W'(r_cmd.x);
          r_fb_wdata <= {20'h0, r_cmd.color};
          if (w_empty) begin
            r_fb_write <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_fb_write <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Without a grant every counter and output simply holds.
          if (w_consume) begin
            if (w_last_col) begin
              r_cx       <= {1'b0, r_cmd.x};
              r_cy       <= r_cy + 9'd1;
              r_row_base <= w_next_row_base;
              r_fb_addr  <= w_next_row_base + ADDR_W'(r_cmd.x);
              if (w_last_row) begin
                r_fb_write <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= ST_DONE;
              end
            end else begin
              r_cx      <= r_cx + 10'd1;
              r_fb_addr <= r_row_base + ADDR_W'(r_cx + 10'd1);
            end
          end
        end
        ST_DONE: begin
          r_done     <= 1'b0;
          r_fb_write <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_done     <= 1'b0;
          r_fb_write <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign fb_write  = r_fb_write;
  assign fb_addr   = r_fb_addr;
  assign fb_wdata  = r_fb_wdata;

endmodule
